rr_sel_arbiter: RTL and testbench

//   Round-robin arbiter that generates the registered 2-bit select consumed by the

---
 rtl/rr_sel_arbiter_pkg.sv | 31 +++
 rtl/rr_sel_arbiter_if.sv | 33 +++
 rtl/rr_sel_arbiter_pick.sv | 56 +++++
 rtl/rr_sel_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_sel_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types, limits and helpers for the round-robin select arbiter.
//   arb_state_e : arbiter FSM state encoding
//   ARB_MAX_REQ : widest request vector supported
//   rr_rotate   : rotate a request vector so a chosen index lands at bit 0
package rr_sel_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    localparam int unsigned ARB_MAX_REQ = 16;
    localparam int unsigned ARB_IDX_W   = $clog2(ARB_MAX_REQ);

    // Bit i of the result is bit (i + sh) mod n of vec; bits at and above n are zero.
    function automatic logic [ARB_MAX_REQ-1:0] rr_rotate(
        input logic [ARB_MAX_REQ-1:0] vec,
        input int unsigned            n,
        input int unsigned            sh
    );
        logic [ARB_MAX_REQ-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
            if (i < n) begin
                r[ARB_IDX_W'(i)] = vec[ARB_IDX_W'((i + sh) % n)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/select bundle between requesters and the arbiter.
//   req       : request vector, bit i = requester i
//   done      : owner end-of-transaction pulse
//   sel       : encoded granted index
//   sel_valid : sel is owned and meaningful
//   timeout   : grant was force-released by the hold limit
interface rr_sel_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  sel_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output sel_valid,
        output timeout
    );
endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// Combinational round-robin pick: rotates req so last_ptr+1 sits at bit 0,
// priority-encodes it and maps the offset back to a requester index.
//   req       : request vector
//   last_ptr  : most recently granted index (lowest priority)
//   cur_sel   : current select, returned when nothing matches cleanly
//   pick_c    : chosen requester index
//   any_req_c : at least one request was found
module rr_sel_arbiter_pick
    import rr_sel_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_ptr,
    input  logic [$clog2(NUM_REQ)-1:0] cur_sel,
    output logic [$clog2(NUM_REQ)-1:0] pick_c,
    output logic                       any_req_c
);
    localparam int unsigned SEL_W = $clog2(NUM_REQ);

    logic [SEL_W-1:0]       start;
    logic [ARB_MAX_REQ-1:0] rot;
    logic [ARB_IDX_W-1:0]   off;

    // NUM_REQ is a power of two, so SEL_W-bit arithmetic wraps modulo NUM_REQ.
    assign start = last_ptr + SEL_W'(1);
    assign rot   = rr_rotate(ARB_MAX_REQ'(req), NUM_REQ, 32'(start));

    // Priority encode the rotated vector; X/Z bits never match a '1' pattern.
    always_comb begin
        off       = '0;
        any_req_c = 1'b0;
        priority casez (rot)
            16'b???????????????1: begin off = 4'd0;  any_req_c = 1'b1; end
            16'b??????????????10: begin off = 4'd1;  any_req_c = 1'b1; end
            16'b?????????????100: begin off = 4'd2;  any_req_c = 1'b1; end
            16'b????????????1000: begin off = 4'd3;  any_req_c = 1'b1; end
            16'b???????????10000: begin off = 4'd4;  any_req_c = 1'b1; end
            16'b??????????100000: begin off = 4'd5;  any_req_c = 1'b1; end
            16'b?????????1000000: begin off = 4'd6;  any_req_c = 1'b1; end
            16'b????????10000000: begin off = 4'd7;  any_req_c = 1'b1; end
            16'b???????100000000: begin off = 4'd8;  any_req_c = 1'b1; end
            16'b??????1000000000: begin off = 4'd9;  any_req_c = 1'b1; end
            16'b?????10000000000: begin off = 4'd10; any_req_c = 1'b1; end
            16'b????100000000000: begin off = 4'd11; any_req_c = 1'b1; end
            16'b???1000000000000: begin off = 4'd12; any_req_c = 1'b1; end
            16'b??10000000000000: begin off = 4'd13; any_req_c = 1'b1; end
            16'b?100000000000000: begin off = 4'd14; any_req_c = 1'b1; end
            16'b1000000000000000: begin off = 4'd15; any_req_c = 1'b1; end
            default: begin end
        endcase
    end

    assign pick_c = any_req_c ? (SEL_W'(off) + start) : cur_sel;

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered select for the one-hot decoder.
// A grant is held until done, loss of the owner's request, or the MAX_HOLD
// limit; a one-cycle gap always separates grants so sel never changes while
// sel_valid is high.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : req/done in; sel/sel_valid/timeout out (all registered)
// NUM_REQ must be a power of two in 2..16; MAX_HOLD = 0 disables the limit.
module rr_sel_arbiter
    import rr_sel_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_sel_arbiter_if.slave bus
);
    localparam int unsigned SEL_W     = $clog2(NUM_REQ);
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam int unsigned HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

    arb_state_e        state_q,     state_d;
    logic [SEL_W-1:0]  sel_q,       sel_d;
    logic [SEL_W-1:0]  last_ptr_q,  last_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic              sel_valid_q, sel_valid_d;
    logic              timeout_q,   timeout_d;

    logic [SEL_W-1:0]  pick_c;
    logic              any_req_c;
    logic              limit_c;
    logic              owner_req_c;
    logic              release_c;

    rr_sel_arbiter_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (bus.req),
        .last_ptr  (last_ptr_q),
        .cur_sel   (sel_q),
        .pick_c    (pick_c),
        .any_req_c (any_req_c)
    );

    assign limit_c     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(HOLD_LAST));
    assign owner_req_c = bus.req[sel_q];
    assign release_c   = bus.done || !owner_req_c || limit_c;

    // State register and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            sel_q       <= '0;
            last_ptr_q  <= SEL_W'(NUM_REQ - 1);
            hold_cnt_q  <= '0;
            sel_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_ptr_q  <= last_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            sel_valid_q <= sel_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_ptr_d  = last_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        sel_valid_d = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                hold_cnt_d = '0;
                if (any_req_c) begin
                    sel_d       = pick_c;
                    last_ptr_d  = pick_c;
                    sel_valid_d = 1'b1;
                    state_d     = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (release_c) begin
                    hold_cnt_d = '0;
                    state_d    = ARB_IDLE;
                    // Only a pure limit release is reported as a timeout.
                    timeout_d  = limit_c && !bus.done && owner_req_c;
                end else begin
                    hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
                    sel_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.timeout   = timeout_q;

`ifndef SYNTHESIS
    // sel must not move while a grant is live.
    a_sel_stable: assert property (@(posedge clk) disable iff (!rst_n)
        sel_valid_q |=> (!sel_valid_q || $stable(sel_q)));

    // A grant is only issued to an active requester.
    a_grant_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ARB_IDLE && any_req_c) |-> bus.req[pick_c]);

    a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(sel_q));

    a_inputs_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({bus.req, bus.done}));
`endif

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter (NUM_REQ=4, MAX_HOLD=8).
module tb_rr_sel_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned MAX_HOLD = 8;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_grant_q[$];
    logic        prev_valid;

    rr_sel_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    rr_sel_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic t);
        chk({tag, "_valid"}, 32'(bus.sel_valid), 32'(v));
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    // Scoreboard: every new grant pops the next expected requester index.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst_n && bus.sel_valid && !prev_valid) begin
            if (exp_grant_q.size() == 0) begin
                chk("grant_expected", 32'(exp_grant_q.size()), 32'd1);
            end else begin
                chk("grant_sel", 32'(bus.sel), exp_grant_q.pop_front());
            end
        end
        prev_valid = rst_n && bus.sel_valid;
    end

    initial begin
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;

        // 1: idle after reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("rst_sel", 32'(bus.sel), 32'd0);
            chk_out("rst", 1'b0, 1'b0);
            tick();
        end

        // done while idle is ignored
        bus.done = 1'b1;
        tick();
        chk_out("idle_done", 1'b0, 1'b0);
        bus.done = 1'b0;

        // 2: single requester, done after 3 valid cycles, then re-grant
        bus.req = 4'b0100;
        exp_grant_q.push_back(32'd2);
        tick();
        chk_out("t2_c1", 1'b1, 1'b0);
        tick();
        chk_out("t2_c2", 1'b1, 1'b0);
        tick();
        chk_out("t2_c3", 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        chk_out("t2_gap", 1'b0, 1'b0);
        bus.done = 1'b0;
        exp_grant_q.push_back(32'd2);
        tick();
        chk_out("t2_regrant", 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk_out("t2_drop", 1'b0, 1'b0);
        tick();
        chk_out("t2_stay_idle", 1'b0, 1'b0);

        // 3: all requesting, done on the 2nd grant cycle -> 0,1,2,3,0
        do_reset();
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_grant_q.push_back(32'(g % 4));
            tick();
            chk_out("t3_grant", 1'b1, 1'b0);
            tick();
            chk_out("t3_hold", 1'b1, 1'b0);
            bus.done = 1'b1;
            tick();
            chk_out("t3_gap", 1'b0, 1'b0);
            bus.done = 1'b0;
        end
        bus.req = 4'b0000;
        tick();

        // 4: hold limit forces release after 8 valid cycles
        do_reset();
        bus.req = 4'b0010;
        exp_grant_q.push_back(32'd1);
        tick();
        chk_out("t4_c1", 1'b1, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk_out("t4_hold", 1'b1, 1'b0);
        end
        tick();
        chk_out("t4_release", 1'b0, 1'b1);
        exp_grant_q.push_back(32'd1);
        tick();
        chk_out("t4_regrant", 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        chk_out("t4_drop", 1'b0, 1'b0);

        // 5: reset mid-grant drops sel_valid immediately, priority restarts at 0
        do_reset();
        bus.req = 4'b1000;
        exp_grant_q.push_back(32'd3);
        tick();
        chk_out("t5_grant", 1'b1, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5_async", 1'b0, 1'b0);
        chk("t5_async_sel", 32'(bus.sel), 32'd0);
        bus.req = 4'b1001;
        tick();
        tick();
        rst_n = 1'b1;
        exp_grant_q.push_back(32'd0);
        tick();
        chk_out("t5_after", 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        chk_out("t5_done", 1'b0, 1'b0);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();

        // 6a: done coincides with the hold limit -> normal release, 1 idle cycle
        do_reset();
        bus.req = 4'b0001;
        exp_grant_q.push_back(32'd0);
        tick();
        for (int c = 2; c <= 8; c++) begin
            tick();
        end
        chk_out("t6a_last_hold", 1'b1, 1'b0);
        bus.done = 1'b1;
        tick();
        chk_out("t6a_release", 1'b0, 1'b0);
        bus.done = 1'b0;
        exp_grant_q.push_back(32'd0);
        tick();
        chk_out("t6a_regrant", 1'b1, 1'b0);

        // 6b: owner request drops together with done -> single release
        tick();
        bus.req  = 4'b0000;
        bus.done = 1'b1;
        tick();
        chk_out("t6b_release", 1'b0, 1'b0);
        bus.done = 1'b0;
        tick();
        chk_out("t6b_idle", 1'b0, 1'b0);
        bus.req = 4'b0001;
        exp_grant_q.push_back(32'd0);
        tick();
        chk_out("t6b_regrant", 1'b1, 1'b0);
        bus.req = 4'b0000;
        tick();
        tick();

        chk("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
